// File: rtl/phase_sel.sv
// Phase tap selector: steps a tap index up or down with a lock-out after each step.
// Define PHASE_SEL_ACCUM_EN to require THRESH net votes before each step.
module phase_sel #(
   parameter int N_PHASES = 8,
   parameter int SEL_W    = $clog2(N_PHASES),
   parameter int HOLDOFF  = 4,
   parameter int INIT_SEL = 0,
   parameter int THRESH   = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_PHASES-1:0] phases,
   input  logic                req_valid,
   input  logic                req_dir,
   output logic                req_ready,
   output logic [SEL_W-1:0]    sel,
   output logic                out,
   output logic                wrap
);
   localparam int               CNT_W     = $clog2(HOLDOFF + 1);
   localparam logic [SEL_W-1:0] LAST      = SEL_W'(N_PHASES - 1);
   localparam logic [SEL_W-1:0] INIT      = SEL_W'(INIT_SEL);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF);

   if (N_PHASES < 2 || HOLDOFF < 1 || INIT_SEL < 0 || INIT_SEL >= N_PHASES || THRESH < 1)
   begin : g_param_check
      $error("phase_sel: illegal parameter set");
   end

   typedef enum logic {IDLE, HOLD} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             do_step;
   logic             step_up;
   logic             crosses;
   logic [SEL_W-1:0] sel_next;

   // Handshake: a request transfers on a rising edge where req_valid and req_ready
   // are both 1. req_ready comes from registered state only and is low in reset.
   assign req_ready = rst_n && (state == IDLE);
   assign accept    = req_valid && req_ready;

`ifdef PHASE_SEL_ACCUM_EN
   localparam int ACC_W = $clog2(THRESH) + 1;

   logic signed [ACC_W-1:0] acc;
   int                      acc_sum;

   // Sum is formed wide so reaching +/-THRESH never has to be stored.
   always_comb begin
      acc_sum = int'(acc);
      if (accept) begin
         acc_sum = req_dir ? acc_sum + 1 : acc_sum - 1;
      end
   end

   assign do_step = accept && (acc_sum >= THRESH || acc_sum <= -THRESH);
   assign step_up = (acc_sum > 0);
`else
   assign do_step = accept;
   assign step_up = req_dir;
`endif

   // Explicit wrap compares keep sel below N_PHASES for non-power-of-two tap counts.
   always_comb begin
      sel_next = '0;
      crosses  = 1'b0;
      if (step_up) begin
         crosses  = (sel == LAST);
         sel_next = crosses ? '0 : sel + SEL_W'(1);
      end else begin
         crosses  = (sel == '0);
         sel_next = crosses ? LAST : sel - SEL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         sel   <= INIT;
         out   <= 1'b0;
         wrap  <= 1'b0;
`ifdef PHASE_SEL_ACCUM_EN
         acc   <= '0;
`endif
      end else begin
         out  <= phases[sel];
         wrap <= 1'b0;
         case (state)
            IDLE: begin
               if (do_step) begin
                  sel   <= sel_next;
                  wrap  <= crosses;
                  state <= HOLD;
                  cnt   <= HOLD_LOAD;
               end
            end
            HOLD: begin
               if (cnt <= CNT_W'(1)) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
`ifdef PHASE_SEL_ACCUM_EN
         if (accept) begin
            acc <= do_step ? '0 : ACC_W'(acc_sum);
         end
`endif
      end
   end
endmodule

// File: tb/tb_phase_sel.sv
// Self-checking bench for phase_sel: reset, sweeps, wrap, held requests, reset abort, voting.
// Expectations follow PHASE_SEL_ACCUM_EN when it is defined for the build.
module tb_phase_sel;
   localparam int N  = 8;
   localparam int SW = 3;
   localparam int HO = 4;
   localparam int TH = 3;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic [N-1:0]  phases    = 8'b10101010;
   logic          req_valid = 1'b0;
   logic          req_dir   = 1'b0;
   logic          req_ready;
   logic [SW-1:0] sel;
   logic          out;
   logic          wrap;

   int n_vec = 0;
   int n_err = 0;

   // Scoreboard entries are {wrap, sel} expected right after a step edge.
   logic [SW:0] exp_q[$];
   int          m_sel = 0;
   int          m_acc = 0;

   always #5 clk = ~clk;

   phase_sel #(
      .N_PHASES(N),
      .HOLDOFF (HO),
      .INIT_SEL(0),
      .THRESH  (TH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .phases   (phases),
      .req_valid(req_valid),
      .req_dir  (req_dir),
      .req_ready(req_ready),
      .sel      (sel),
      .out      (out),
      .wrap     (wrap)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model of one accepted request; pushes the expected result on a step.
   task automatic model_req(input logic dir, output bit stepped);
      bit up;
      int nxt;
      bit w;
      up      = dir;
      stepped = 1'b0;
`ifdef PHASE_SEL_ACCUM_EN
      m_acc = dir ? m_acc + 1 : m_acc - 1;
      if (m_acc >= TH || m_acc <= -TH) begin
         up      = (m_acc > 0);
         m_acc   = 0;
         stepped = 1'b1;
      end
`else
      stepped = 1'b1;
`endif
      if (stepped) begin
         nxt   = up ? (m_sel + 1) % N : (m_sel + N - 1) % N;
         w     = (up && m_sel == N - 1) || (!up && m_sel == 0);
         m_sel = nxt;
         exp_q.push_back({w, nxt[SW-1:0]});
      end
   endtask

   // Driver: waits (bounded) for req_ready, presents one request for one edge.
   task automatic send_req(input logic dir, output bit stepped, output bit timed_out);
      int waited;
      waited    = 0;
      stepped   = 1'b0;
      timed_out = 1'b0;
      while (req_ready !== 1'b1 && waited < 50) begin
         tick();
         waited++;
      end
      if (req_ready !== 1'b1) begin
         timed_out = 1'b1;
         return;
      end
      req_valid = 1'b1;
      req_dir   = dir;
      model_req(dir, stepped);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      n_vec++;
      if ({req_ready, wrap, out, sel} !== {1'b0, 1'b0, 1'b0, 3'd0}) begin
         n_err++;
         $display("FAIL reset_hold: ready/wrap/out/sel=%b/%b/%b/%0d required 0/0/0/0",
                  req_ready, wrap, out, sel);
      end
      tick();
      n_vec++;
      if (req_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ready_low: req_ready=%b required 0", req_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_vec++;
      if (req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_release_ready: req_ready=%b required 1", req_ready);
      end
      tick();
      n_vec++;
      if ({sel, wrap, out, req_ready} !== {3'd0, 1'b0, phases[0], 1'b1}) begin
         n_err++;
         $display("FAIL reset_first_cycle: sel/wrap/out/ready=%0d/%b/%b/%b required 0/0/%b/1",
                  sel, wrap, out, req_ready, phases[0]);
      end
   endtask

   task automatic test_up_sweep();
      bit          stepped;
      bit          to;
      logic [SW:0] exp;
      for (int i = 0; i < 8; i++) begin
         send_req(1'b1, stepped, to);
         n_vec++;
         if (to) begin
            n_err++;
            $display("FAIL sweep_ready_timeout: req_ready=%b required 1", req_ready);
         end else if (stepped) begin
            exp = exp_q.pop_front();
            if ({wrap, sel} !== exp) begin
               n_err++;
               $display("FAIL sweep_step%0d: wrap/sel=%b/%0d required %b/%0d",
                        i, wrap, sel, exp[SW], exp[SW-1:0]);
            end
         end else if ({wrap, sel} !== {1'b0, m_sel[SW-1:0]}) begin
            n_err++;
            $display("FAIL sweep_vote%0d: wrap/sel=%b/%0d required 0/%0d", i, wrap, sel, m_sel);
         end
         n_vec++;
         if (req_ready !== !stepped) begin
            n_err++;
            $display("FAIL sweep_ready%0d: req_ready=%b required %b", i, req_ready, !stepped);
         end
         tick();
         n_vec++;
         if ({out, wrap} !== {phases[m_sel], 1'b0}) begin
            n_err++;
            $display("FAIL sweep_out%0d: out/wrap=%b/%b required %b/0",
                     i, out, wrap, phases[m_sel]);
         end
      end
   endtask

   task automatic test_down_wrap();
      bit          stepped;
      bit          to;
      int          tries;
      logic [SW:0] exp;
      tries   = 0;
      stepped = 1'b0;
      to      = 1'b0;
      while (!stepped && !to && tries < 5) begin
         send_req(1'b0, stepped, to);
         tries++;
      end
      n_vec++;
      if (!stepped) begin
         n_err++;
         $display("FAIL down_no_step: sel=%0d required a step (ready=%b)", sel, req_ready);
      end else begin
         exp = exp_q.pop_front();
         if ({wrap, sel} !== exp) begin
            n_err++;
            $display("FAIL down_wrap: wrap/sel=%b/%0d required %b/%0d",
                     wrap, sel, exp[SW], exp[SW-1:0]);
         end
      end
      tick();
      n_vec++;
      if ({out, wrap} !== {phases[m_sel], 1'b0}) begin
         n_err++;
         $display("FAIL down_out: out/wrap=%b/%b required %b/0", out, wrap, phases[m_sel]);
      end
   endtask

   task automatic test_held();
      bit            stepped;
      int            m_hold;
      int            steps_dut;
      int            steps_model;
      int            waited;
      logic [SW-1:0] prev;
      logic [SW:0]   exp;
      m_hold      = 0;
      steps_dut   = 0;
      steps_model = 0;
      waited      = 0;
      while (req_ready !== 1'b1 && waited < 50) begin
         tick();
         waited++;
      end
      req_valid = 1'b1;
      req_dir   = 1'b1;
      for (int c = 0; c < 20; c++) begin
         prev    = sel;
         stepped = 1'b0;
         if (m_hold == 0) begin
            model_req(1'b1, stepped);
            if (stepped) begin
               m_hold = HO;
               steps_model++;
            end
         end else begin
            m_hold--;
         end
         tick();
         if (sel !== prev) steps_dut++;
         if (stepped) begin
            exp = exp_q.pop_front();
            n_vec++;
            if ({wrap, sel} !== exp) begin
               n_err++;
               $display("FAIL held_step_c%0d: wrap/sel=%b/%0d required %b/%0d",
                        c, wrap, sel, exp[SW], exp[SW-1:0]);
            end
         end
         n_vec++;
         if (req_ready !== logic'(m_hold == 0)) begin
            n_err++;
            $display("FAIL held_ready_c%0d: req_ready=%b required %b", c, req_ready, m_hold == 0);
         end
      end
      req_valid = 1'b0;
      n_vec++;
      if (steps_dut != steps_model) begin
         n_err++;
         $display("FAIL held_step_count: steps=%0d required %0d", steps_dut, steps_model);
      end
   endtask

   task automatic test_phase_change();
      for (int i = 0; i < 6; i++) begin
         phases = N'($urandom_range(0, (1 << N) - 1));
         tick();
         n_vec++;
         if (out !== phases[m_sel]) begin
            n_err++;
            $display("FAIL phase_change%0d: out=%b required %b (phases=%b)",
                     i, out, phases[m_sel], phases);
         end
      end
      phases = 8'b10101010;
      tick();
   endtask

   task automatic test_reset_mid();
      bit          stepped;
      bit          to;
      int          tries;
      logic [SW:0] exp;
      tries   = 0;
      stepped = 1'b0;
      to      = 1'b0;
      while (!(stepped && m_sel == 5) && !to && tries < 40) begin
         send_req(1'b1, stepped, to);
         if (stepped) begin
            exp = exp_q.pop_front();
            n_vec++;
            if ({wrap, sel} !== exp) begin
               n_err++;
               $display("FAIL rmid_step%0d: wrap/sel=%b/%0d required %b/%0d",
                        tries, wrap, sel, exp[SW], exp[SW-1:0]);
            end
         end
         tries++;
      end
      tick();
      n_vec++;
      if ({sel, req_ready} !== {3'd5, 1'b0}) begin
         n_err++;
         $display("FAIL rmid_in_hold: sel/ready=%0d/%b required 5/0", sel, req_ready);
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({sel, req_ready, wrap, out} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL rmid_async: sel/ready/wrap/out=%0d/%b/%b/%b required 0/0/0/0",
                  sel, req_ready, wrap, out);
      end
      m_sel = 0;
      m_acc = 0;
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_vec++;
      if (req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL rmid_release_ready: req_ready=%b required 1", req_ready);
      end
      tick();
      n_vec++;
      if ({sel, req_ready} !== {3'd0, 1'b1}) begin
         n_err++;
         $display("FAIL rmid_no_pending: sel/ready=%0d/%b required 0/1", sel, req_ready);
      end
   endtask

   task automatic test_vote_pattern();
      logic [4:0]  dirs;
      bit          stepped;
      bit          to;
      logic [SW:0] exp;
      dirs = 5'b11011;
      for (int i = 0; i < 5; i++) begin
         send_req(dirs[4-i], stepped, to);
         n_vec++;
         if (to) begin
            n_err++;
            $display("FAIL vote_ready_timeout%0d: req_ready=%b required 1", i, req_ready);
         end else if (stepped) begin
            exp = exp_q.pop_front();
            if ({wrap, sel} !== exp) begin
               n_err++;
               $display("FAIL vote_step%0d: wrap/sel=%b/%0d required %b/%0d",
                        i, wrap, sel, exp[SW], exp[SW-1:0]);
            end
         end else if ({wrap, sel, req_ready} !== {1'b0, m_sel[SW-1:0], 1'b1}) begin
            n_err++;
            $display("FAIL vote_idle%0d: wrap/sel/ready=%b/%0d/%b required 0/%0d/1",
                     i, wrap, sel, req_ready, m_sel);
         end
      end
      n_vec++;
      if (sel !== m_sel[SW-1:0]) begin
         n_err++;
         $display("FAIL vote_final_sel: sel=%0d required %0d", sel, m_sel);
      end
   endtask

   initial begin
      test_reset();
      test_up_sweep();
      test_down_wrap();
      test_held();
      test_phase_change();
      test_reset_mid();
      test_vote_pattern();
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/phase_sel.md
PHASE_SEL -- requirements
Module: phase_sel

Interface
REQ-001 Parameter N_PHASES, default 8: number of phase taps; SHALL be at least 2.
REQ-002 Parameter SEL_W, default $clog2(N_PHASES): select width.
REQ-003 Parameter HOLDOFF, default 4: lock-out cycles after each step; SHALL be at least 1.
REQ-004 Parameter INIT_SEL, default 0: select value loaded at reset; SHALL be less than N_PHASES.
REQ-005 Parameter THRESH, default 3: vote threshold; used only when PHASE_SEL_ACCUM_EN is defined.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous and active-low.
REQ-008 phases  input  N_PHASES  phase taps; bit i is tap i.
REQ-009 req_valid  input  1  step request present.
REQ-010 req_dir  input  1  step direction; 1 = up (+1), 0 = down (-1); qualified by req_valid.
REQ-011 req_ready  output  1  block can accept a request.
REQ-012 sel  output  SEL_W  current tap index, registered.
REQ-013 out  output  1  registered copy of phases[sel].
REQ-014 wrap  output  1  one-cycle pulse on a step that crosses the N_PHASES-1/0 boundary in either direction.

Function
REQ-015 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; otherwise it SHALL be ignored, with no stored effect.
REQ-016 State machine: IDLE (req_ready = 1) and HOLD (req_ready = 0); req_ready SHALL be decoded from registered state only.
REQ-017 Step on accepted request at edge T: sel SHALL take its new value at T, state SHALL become HOLD, and the hold counter SHALL load HOLDOFF.
REQ-018 Step arithmetic: up gives (sel+1) mod N_PHASES, down gives (sel-1) mod N_PHASES; sel SHALL never hold a value of N_PHASES or more, including when N_PHASES is not a power of two.
REQ-019 wrap SHALL be 1 for exactly the cycle after a step from N_PHASES-1 to 0 or from 0 to N_PHASES-1, and 0 otherwise.
REQ-020 HOLD SHALL decrement the counter each cycle; after HOLDOFF cycles in HOLD, state SHALL return to IDLE.
REQ-021 Consequently, a continuously asserted req_valid SHALL step once every HOLDOFF+1 cycles.
REQ-022 out SHALL be phases[sel] registered on each edge, giving one cycle of latency from a sel change or a phases change.
REQ-023 req_valid during HOLD SHALL have no effect on sel, wrap, or the counter.

Reset
REQ-024 While rst_n = 0, regardless of clk: sel = INIT_SEL, out = 0, wrap = 0, state = IDLE, counter = 0, accumulator = 0.
REQ-025 req_ready SHALL be 0 while rst_n = 0, and 1 on the first cycle after deassertion.
REQ-026 Reset asserted mid-HOLD SHALL abort the hold; no pending step or vote SHALL survive reset.

Configuration
REQ-027 Macro PHASE_SEL_ACCUM_EN defined: each accepted request SHALL add +1 (up) or -1 (down) to a signed accumulator.
REQ-028 In that mode, a step SHALL occur only when the accumulator would reach +THRESH or -THRESH; the step direction SHALL follow the sign, the accumulator SHALL clear, and the block SHALL enter HOLD.
REQ-029 In that mode, a request that does not reach threshold SHALL leave the block in IDLE with req_ready = 1.
REQ-030 In that mode, the accumulator width SHALL be $clog2(THRESH)+1 bits and SHALL never saturate past plus or minus THRESH.
REQ-031 Macro PHASE_SEL_ACCUM_EN undefined: no accumulator SHALL exist, every accepted request SHALL step directly, and THRESH SHALL be unused.

Verification
REQ-032 Reset: N_PHASES=8, INIT_SEL=0, phases=8'b10101010, release rst_n -> sel=0, wrap=0, req_ready=1, and out=0 one cycle later.
REQ-033 Up sweep: eight up requests, each issued when req_ready=1 -> sel steps 1..7 then 0; wrap pulses only on the 7->0 step; out follows 1,0,1,0,... with one cycle of lag.
REQ-034 Down wrap: at sel=0, one down request -> sel=7, wrap=1 for one cycle, out=phases[7]=1.
REQ-035 Held request: req_valid=1, req_dir=1 for 20 cycles with HOLDOFF=4 -> exactly 4 steps, spaced 5 cycles apart; req_ready low for 4 cycles after each step.
REQ-036 Reset mid-operation: assert rst_n=0 two cycles into HOLD at sel=5 -> sel=INIT_SEL immediately; req_ready=1 on the first cycle after release.
REQ-037 With PHASE_SEL_ACCUM_EN and THRESH=3: requests up, up, down, up, up -> exactly one up step, after the fifth request, with the accumulator cleared; without the macro, the same stimulus -> net three up steps.
